mux_serializer: RTL and testbench
=================================

MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = channel 0 sent first, 0 = channel 15 sent first.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, a 16-bit word is offered on in_data.
REQ-005 SHALL have port in_data, input, 16, parallel word; bit k = mux channel k.
REQ-006 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-007 SHALL have port out_valid, output, 1, out_bit is valid.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts out_bit this cycle.
REQ-009 SHALL have port out_bit, output, 1, currently selected channel of the held word.
REQ-010 SHALL have port out_last, output, 1, high with out_valid on the final bit of a word.
REQ-011 SHALL have port sel, output, 4, current channel index driving the mux select.
REQ-012 SHALL have port flush, input, 1, synchronous abort of the word in progress.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 In IDLE: in_ready=1, out_valid=0; an in_valid&in_ready transfer captures in_data into the hold register, loads sel with the first index (0 if LSB_FIRST, else 15) and moves to SHIFT.
REQ-015 First bit SHALL be valid on the cycle after acceptance (latency 1).
REQ-016 In SHIFT: out_valid=1; out_bit = hold[sel], combinational from registered hold and sel.
REQ-017 A beat completes when out_valid&out_ready; sel then steps +1 (LSB_FIRST) or -1; no step without out_ready; out_bit and sel held stable while stalled.
REQ-018 out_last SHALL be 1 exactly when in SHIFT and sel equals the last index (15 if LSB_FIRST, else 0).
REQ-019 On completion of the last beat: with in_valid=1, SHALL load the new word and stay in SHIFT (back-to-back, no bubble); otherwise go to IDLE.
REQ-020 in_ready SHALL equal IDLE | (SHIFT & out_last & out_ready) while flush=0; this combinational path from out_ready is permitted.
REQ-021 Exactly 16 beats per accepted word; sel wrap from last index SHALL never be emitted as a 17th beat.
REQ-022 flush=1 SHALL force in_ready=0, discard the held word and enter IDLE next cycle; flush overrides in_valid, out_ready and last-beat reload.
REQ-023 hold register SHALL change only on an accepted transfer.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, hold=16'h0000, sel=4'h0, hence out_valid=0, out_last=0, out_bit=0, in_ready=1 after release.
REQ-025 Reset mid-word SHALL drop the word; no partial beats after release.
REQ-026 First acceptance SHALL be possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 Package mux_pkg SHALL hold N_CH=16, SEL_W=4 and the IDLE/SHIFT state encoding.
REQ-028 Bit selection SHALL instantiate the existing mux16x1 (i=hold, s=sel, y=out_bit); no duplicate select logic.
REQ-029 Target size 120-250 lines RTL; no other sub-modules.

Verification
REQ-030 Reset then send 16'b0110101000011101 with out_ready=1, LSB_FIRST=1 -> bits 1,0,1,1,1,0,0,0,0,1,0,1,0,1,1,0 on cycles 1..16, out_last only on 16th, sel 0..15.
REQ-031 Same word, LSB_FIRST=0 -> reversed stream 0,1,1,0,1,0,1,0,0,0,0,1,1,1,0,1, sel 15..0.
REQ-032 out_ready low for 3 cycles at sel=5 -> sel, out_bit, out_valid held 3 cycles, then resume at sel=6; 16 beats total.
REQ-033 Two words 16'hFFFF then 16'h0000 with in_valid held high -> 32 contiguous beats, second word accepted on the out_last beat, no idle gap.
REQ-034 flush at sel=7 with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, state IDLE, then new word starts at sel=0.
REQ-035 rst_n low at sel=9 -> out_valid=0 immediately (asynchronous), sel=0, hold=0; no residual beats after release.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared widths and FSM state encoding for the mux serializer
package mux_pkg;
   localparam int N_CH  = 16;
   localparam int SEL_W = 4;
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/mux_serializer_if.sv
// mux_serializer_if: parallel-in / serial-out handshake bundle
interface mux_serializer_if;
   import mux_pkg::*;
   logic             in_valid;
   logic [N_CH-1:0]  in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic             out_last;
   logic [SEL_W-1:0] sel;
   logic             flush;
   modport master (output in_valid, in_data, out_ready, flush,
                   input in_ready, out_valid, out_bit, out_last, sel);
   modport slave  (input in_valid, in_data, out_ready, flush,
                   output in_ready, out_valid, out_bit, out_last, sel);
endinterface

// File: rtl/mux16x1.sv
// mux16x1: 16-to-1 bit multiplexer
module mux16x1
   import mux_pkg::*;
(
   input  logic [N_CH-1:0]  i,
   input  logic [SEL_W-1:0] s,
   output logic             y
);
   assign y = i[s];
endmodule

// File: rtl/mux_serializer.sv
// mux_serializer: holds a 16-bit word and streams it one channel per beat through a mux
module mux_serializer
   import mux_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   mux_serializer_if.slave bus
);
   localparam logic [SEL_W-1:0] FIRST = LSB_FIRST ? '0 : SEL_W'(N_CH - 1);
   localparam logic [SEL_W-1:0] LAST  = LSB_FIRST ? SEL_W'(N_CH - 1) : '0;
   state_t           state;
   logic [N_CH-1:0]  hold;
   logic [SEL_W-1:0] sel;
   logic             shift, accept, beat;
   assign shift         = state == SHIFT;
   assign bus.out_valid = shift;
   assign bus.out_last  = shift && sel == LAST;
   assign bus.in_ready  = !bus.flush && (!shift || (bus.out_last && bus.out_ready));
   assign bus.sel       = sel;
   assign accept        = bus.in_valid && bus.in_ready;
   assign beat          = shift && bus.out_ready;
   mux16x1 u_mux (.i(hold), .s(sel), .y(bus.out_bit));
   // FSM: flush aborts, accepted words (incl. last-beat reload) load hold/sel, beats step sel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hold  <= '0;
         sel   <= '0;
      end else if (bus.flush) begin
         state <= IDLE;
      end else if (accept) begin
         state <= SHIFT;
         hold  <= bus.in_data;
         sel   <= FIRST;
      end else if (beat) begin
         sel   <= LSB_FIRST ? sel + 1'b1 : sel - 1'b1;
         state <= bus.out_last ? IDLE : SHIFT;
      end
   end
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: random + directed checks of both bit orders against a beat-count model
module tb_mux_serializer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [15:0] in_data = '0;
   logic [15:0] stream0, stream1;
   int          checks = 0, failures = 0;
   bit          busy [2];
   int          idx [2];
   logic [15:0] word [2];

   always #5 clk = ~clk;

   mux_serializer_if b0 ();
   mux_serializer_if b1 ();
   assign b0.in_valid = in_valid;
   assign b0.in_data = in_data;
   assign b0.out_ready = out_ready;
   assign b0.flush = flush;
   assign b1.in_valid = in_valid;
   assign b1.in_data = in_data;
   assign b1.out_ready = out_ready;
   assign b1.flush = flush;

   mux_serializer #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   mux_serializer #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_ready(input int d);
      return !flush && (!busy[d] || (idx[d] == 15 && out_ready));
   endfunction

   task automatic check_dut(input int d, input logic ov, input logic ob, input logic ol,
                            input logic ir, input logic [3:0] sl);
      logic [3:0] s;
      s = (d == 0) ? 4'(idx[d]) : 4'(15 - idx[d]);
      chk($sformatf("d%0d out_valid", d), 32'(ov), 32'(busy[d]));
      chk($sformatf("d%0d out_last", d), 32'(ol), 32'(busy[d] && idx[d] == 15));
      chk($sformatf("d%0d in_ready", d), 32'(ir), 32'(exp_ready(d)));
      if (busy[d]) begin
         chk($sformatf("d%0d sel", d), 32'(sl), 32'(s));
         chk($sformatf("d%0d out_bit", d), 32'(ob), 32'(word[d][s]));
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit ir;
         ir = exp_ready(d);
         if (flush) busy[d] = 1'b0;
         else if (in_valid && ir) begin
            word[d] = in_data;
            idx[d] = 0;
            busy[d] = 1'b1;
         end else if (busy[d] && out_ready) begin
            if (idx[d] == 15) busy[d] = 1'b0;
            else idx[d]++;
         end
      end
   endtask

   task automatic cycle();
      #1;
      check_dut(0, b0.out_valid, b0.out_bit, b0.out_last, b0.in_ready, b0.sel);
      check_dut(1, b1.out_valid, b1.out_bit, b1.out_last, b1.in_ready, b1.sel);
      if (busy[0] && out_ready) stream0[idx[0]] = b0.out_bit;
      if (busy[1] && out_ready) stream1[idx[1]] = b1.out_bit;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] w);
      in_valid = 1'b1;
      in_data = w;
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      idx[0] = 0;
      idx[1] = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst out_valid", 32'({b0.out_valid, b1.out_valid}), 32'd0);
      chk("rst out_last", 32'({b0.out_last, b1.out_last}), 32'd0);
      chk("rst out_bit", 32'({b0.out_bit, b1.out_bit}), 32'd0);
      chk("rst sel", 32'({b0.sel, b1.sel}), 32'd0);
      chk("rst in_ready", 32'({b0.in_ready, b1.in_ready}), 32'd3);
      @(negedge clk);
      rst_n = 1'b1;
      // reference word in both orders, first acceptance right after reset
      out_ready = 1'b1;
      stream0 = '0;
      stream1 = '0;
      send(16'b0110101000011101);
      repeat (16) cycle();
      chk("lsb stream", 32'(stream0), 32'h0000_6A1D);
      chk("msb stream", 32'(stream1), 32'h0000_B856);
      cycle();
      // stall three cycles with sel at 5
      send(16'hC3A5);
      repeat (5) cycle();
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready = 1'b1;
      repeat (12) cycle();
      // back-to-back words with in_valid held high
      in_valid = 1'b1;
      in_data = 16'hFFFF;
      cycle();
      in_data = 16'h0000;
      repeat (16) cycle();
      in_valid = 1'b0;
      repeat (17) cycle();
      // flush at sel 7 with in_valid asserted
      send(16'h5A5A);
      in_valid = 1'b1;
      in_data = 16'h1234;
      repeat (7) cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      cycle();
      send(16'h9F31);
      repeat (17) cycle();
      // asynchronous reset mid-word at sel 9
      send(16'hBEEF);
      repeat (9) cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'({b0.out_valid, b1.out_valid}), 32'd0);
      chk("async sel", 32'({b0.sel, b1.sel}), 32'd0);
      chk("async out_bit", 32'({b0.out_bit, b1.out_bit}), 32'd0);
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle();
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = 16'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 40) == 0;
         cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
